// File: rtl/systolic_mesh_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : systolic_mesh_ctrl
// Purpose  : Sequencer for a weight-stationary systolic mesh. It streams
//            MESH_LENGTH weight rows into the mesh top, then feeds image
//            vectors with per-row skew and raises per-column capture strobes
//            when each column result leaves the mesh bottom.
// Revision : 1.0 - initial release
// ============================================================================
module systolic_mesh_ctrl #(
    parameter int DATA_LENGTH = 8,
    parameter int MESH_LENGTH = 4,
    parameter int CNT_WIDTH   = 8,
    localparam int IN_LENGTH  = DATA_LENGTH * MESH_LENGTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [CNT_WIDTH-1:0]   num_vec,
    input  logic                   w_valid,
    output logic                   w_ready,
    input  logic [IN_LENGTH-1:0]   w_data,
    input  logic                   x_valid,
    output logic                   x_ready,
    input  logic [IN_LENGTH-1:0]   x_data,
    output logic [IN_LENGTH-1:0]   mesh_weight,
    output logic                   mesh_weight_load,
    output logic [IN_LENGTH-1:0]   mesh_image,
    output logic [MESH_LENGTH-1:0] mesh_image_load,
    output logic [MESH_LENGTH-1:0] col_capture,
    output logic                   busy,
    output logic                   done
);

    localparam int c_WCNT_WIDTH = $clog2(MESH_LENGTH + 1);
    localparam int c_VLD_DEPTH  = 2 * MESH_LENGTH;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD_W = 3'd1,
        S_WAIT_W = 3'd2,
        S_STREAM = 3'd3,
        S_DRAIN  = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    state_t                   r_state;
    state_t                   w_state_next;
    logic [c_WCNT_WIDTH-1:0]  r_wcnt;       // weight beats in LOAD_W, settle cycles in WAIT_W
    logic [CNT_WIDTH-1:0]     r_vcnt;
    logic [CNT_WIDTH-1:0]     r_num_vec;
    logic [IN_LENGTH-1:0]     r_mesh_weight;
    logic                     r_wload;
    // Bit k marks a vector accepted k+1 cycles ago: low half feeds the row
    // loads, high half lines up with the bottom-of-column results.
    logic [c_VLD_DEPTH-1:0]   r_vld;

    logic w_w_accept;
    logic w_x_accept;
    logic w_last_w;
    logic w_wait_end;
    logic w_last_x;
    logic w_drain_end;

    assign w_w_accept  = w_valid && (r_state == S_LOAD_W);
    assign w_x_accept  = x_valid && (r_state == S_STREAM);
    assign w_last_w    = w_w_accept && (r_wcnt == c_WCNT_WIDTH'(MESH_LENGTH - 1));
    assign w_wait_end  = (r_state == S_WAIT_W) && (r_wcnt == c_WCNT_WIDTH'(MESH_LENGTH - 1));
    // One extra bit so num_vec = all-ones terminates without wrapping.
    assign w_last_x    = w_x_accept && (({1'b0, r_vcnt} + 1'b1) == {1'b0, r_num_vec});
    // Only the strobe now on the last column remains in flight.
    assign w_drain_end = (r_vld[c_VLD_DEPTH-2:0] == '0);

    // Next-state and handshake/status outputs
    always_comb begin
        w_state_next = r_state;
        w_ready      = 1'b0;
        x_ready      = 1'b0;
        busy         = (r_state != S_IDLE);
        done         = 1'b0;
        case (r_state)
            S_IDLE:   if (start) w_state_next = S_LOAD_W;
            S_LOAD_W: begin
                w_ready = 1'b1;
                if (w_last_w) w_state_next = S_WAIT_W;
            end
            S_WAIT_W: if (w_wait_end) w_state_next = (r_num_vec == '0) ? S_DRAIN : S_STREAM;
            S_STREAM: begin
                x_ready = 1'b1;
                if (w_last_x) w_state_next = S_DRAIN;
            end
            S_DRAIN:  if (w_drain_end) w_state_next = S_DONE;
            S_DONE: begin
                done         = 1'b1;
                w_state_next = S_IDLE;
            end
            default:  w_state_next = S_IDLE;
        endcase
    end

    // State register, counters and latched vector count
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_wcnt    <= '0;
            r_vcnt    <= '0;
            r_num_vec <= '0;
        end else begin
            r_state <= w_state_next;
            if ((r_state == S_IDLE) && start) r_num_vec <= num_vec;
            if (w_state_next != r_state)
                r_wcnt <= '0;
            else if (w_w_accept || (r_state == S_WAIT_W))
                r_wcnt <= r_wcnt + c_WCNT_WIDTH'(1);
            if (r_state == S_IDLE)
                r_vcnt <= '0;
            else if (w_x_accept)
                r_vcnt <= r_vcnt + CNT_WIDTH'(1);
        end
    end

    // Weight row register: each accepted beat shifts into the mesh next cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mesh_weight <= '0;
            r_wload       <= 1'b0;
        end else begin
            r_wload <= w_w_accept;
            if (w_w_accept) r_mesh_weight <= w_data;
        end
    end

    // Valid delay line shared by the row loads and column captures
    always_ff @(posedge clk) begin
        if (rst) r_vld <= '0;
        else     r_vld <= {r_vld[c_VLD_DEPTH-2:0], w_x_accept};
    end

    // Row r element is delayed r+1 cycles; bubbles carry zero data
    for (genvar gr = 0; gr < MESH_LENGTH; gr++) begin : g_row
        logic [DATA_LENGTH-1:0] r_pipe [0:gr];
        // Skew shift register for this row
        always_ff @(posedge clk) begin
            if (rst) begin
                for (int k = 0; k <= gr; k++) r_pipe[k] <= '0;
            end else begin
                r_pipe[0] <= w_x_accept ? x_data[gr*DATA_LENGTH +: DATA_LENGTH] : '0;
                for (int k = 1; k <= gr; k++) r_pipe[k] <= r_pipe[k-1];
            end
        end
        assign mesh_image[gr*DATA_LENGTH +: DATA_LENGTH] = r_pipe[gr];
    end

    assign mesh_weight      = r_mesh_weight;
    assign mesh_weight_load = r_wload;
    assign mesh_image_load  = r_vld[MESH_LENGTH-1:0];
    assign col_capture      = r_vld[c_VLD_DEPTH-1:MESH_LENGTH];

endmodule
`default_nettype wire
